// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit-side blocks.
//   UART_DATA_W   : width of one UART character
//   TXQ_*         : state encodings of the uart_tx_queue launch sequencer
//   TXQ_OVF_CNT_W : width of the optional dropped-write counter
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int TXQ_OVF_CNT_W = 16;

    // Launch sequencer states
    localparam logic [1:0] TXQ_IDLE   = 2'd0;
    localparam logic [1:0] TXQ_LAUNCH = 2'd1;
    localparam logic [1:0] TXQ_WAIT   = 2'd2;
    localparam logic [1:0] TXQ_GAP    = 2'd3;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding bytes waiting for transmission.
// Occupancy and flags are registered: a write or read on edge N is reflected in
// count/full/empty right after edge N. Storage is not reset; only pointers,
// count and flags are.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   wr_en    in   push request (ignored while full)
//   wr_data  in   byte to push
//   rd_en    in   pop request (ignored while empty)
//   rd_data  out  head of queue (valid while !empty)
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [CW-1:0]    count_nxt;

    // A write while full is dropped even if a pop happens on the same edge.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
// Byte queue plus launch sequencer feeding the transmit side of uart_top.
// Host bytes are buffered in a FIFO; each is launched with a one-cycle
// tx_data_avail pulse, and the next launch waits for tx_done (plus IDLE_GAP
// extra cycles). At most one byte is in flight at any time.
//
// Build option: define UART_TXQ_OVF_CNT_EN to add ovf_cnt, a saturating count
// of dropped writes cleared only by rst.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   wr_en          in   host write strobe, one byte per cycle
//   wr_data        in   host byte
//   full           out  queue holds DEPTH bytes
//   empty          out  queue holds no bytes
//   count          out  queue occupancy
//   overflow       out  1-cycle pulse: a write arrived while full and was dropped
//   tx_data_avail  out  1-cycle launch pulse to uart_top
//   tx_data_byte   out  byte being transmitted, stable from launch to tx_done
//   tx_active      in   uart_top frame in progress (blocks a launch)
//   tx_done        in   uart_top end-of-frame pulse
//   ovf_cnt        out  dropped-write counter (UART_TXQ_OVF_CNT_EN only)
// -----------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int IDLE_GAP = 0,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count,
    output logic                   overflow,
    output logic                   tx_data_avail,
    output logic [UART_DATA_W-1:0] tx_data_byte,
    input  logic                   tx_active,
    input  logic                   tx_done
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    output logic [TXQ_OVF_CNT_W-1:0] ovf_cnt
`endif
);

    // The gap counter is loaded with IDLE_GAP-1 on tx_done and the GAP state
    // exits when it reads zero, giving exactly IDLE_GAP cycles in GAP.
    localparam logic [7:0] GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

    logic [1:0]             state;
    logic [7:0]             gap_ctr;
    logic                   pop;
    logic                   wr_drop;
    logic [UART_DATA_W-1:0] head_byte;

    assign pop     = (state == TXQ_IDLE) && !empty && !tx_active;
    assign wr_drop = wr_en && full;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head_byte),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Launch sequencer: tx_data_avail is high only in the LAUNCH cycle, so it
    // can never be asserted on two consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= TXQ_IDLE;
            gap_ctr       <= 8'd0;
            tx_data_avail <= 1'b0;
            tx_data_byte  <= '0;
        end else begin
            tx_data_avail <= 1'b0;
            case (state)
                TXQ_IDLE: begin
                    if (pop) begin
                        state         <= TXQ_LAUNCH;
                        tx_data_avail <= 1'b1;
                        tx_data_byte  <= head_byte;
                    end
                end
                TXQ_LAUNCH: begin
                    state <= TXQ_WAIT;
                end
                TXQ_WAIT: begin
                    // tx_done is only meaningful here; elsewhere it is ignored.
                    if (tx_done) begin
                        if (IDLE_GAP > 0) begin
                            state   <= TXQ_GAP;
                            gap_ctr <= GAP_LOAD;
                        end else begin
                            state <= TXQ_IDLE;
                        end
                    end
                end
                TXQ_GAP: begin
                    if (gap_ctr == 8'd0) begin
                        state <= TXQ_IDLE;
                    end else begin
                        gap_ctr <= gap_ctr - 8'd1;
                    end
                end
                default: begin
                    state <= TXQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_drop;
        end
    end

`ifdef UART_TXQ_OVF_CNT_EN
    function automatic logic [TXQ_OVF_CNT_W-1:0] sat_inc(input logic [TXQ_OVF_CNT_W-1:0] v);
        return (v == '1) ? v : v + TXQ_OVF_CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (wr_drop) begin
            ovf_cnt <= sat_inc(ovf_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
`timescale 1ns/1ps
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 4;
    localparam int GAP0  = 0;
    localparam int GAP1  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [7:0]    wr_data;
    logic [1:0]    wr_en_v;
    logic [1:0]    auto_v, man_active_v, man_done_v, r_active_v, r_done_v;
    logic [1:0]    tx_active_v, tx_done_v;
    logic [1:0]    full_v, empty_v, ovf_v, avail_v;
    logic [7:0]    byte0, byte1;
    logic [CW-1:0] count0, count1;
`ifdef UART_TXQ_OVF_CNT_EN
    logic [15:0]   ovfc0, ovfc1;
`endif

    // Each DUT is driven either by the auto uart_top stand-in or by hand.
    assign tx_active_v = (auto_v & r_active_v) | (~auto_v & man_active_v);
    assign tx_done_v   = (auto_v & r_done_v)   | (~auto_v & man_done_v);

    uart_tx_queue #(.DEPTH(DEPTH), .IDLE_GAP(GAP0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en_v[0]), .wr_data(wr_data),
        .full(full_v[0]), .empty(empty_v[0]), .count(count0), .overflow(ovf_v[0]),
        .tx_data_avail(avail_v[0]), .tx_data_byte(byte0),
        .tx_active(tx_active_v[0]), .tx_done(tx_done_v[0])
`ifdef UART_TXQ_OVF_CNT_EN
        , .ovf_cnt(ovfc0)
`endif
    );

    uart_tx_queue #(.DEPTH(DEPTH), .IDLE_GAP(GAP1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en_v[1]), .wr_data(wr_data),
        .full(full_v[1]), .empty(empty_v[1]), .count(count1), .overflow(ovf_v[1]),
        .tx_data_avail(avail_v[1]), .tx_data_byte(byte1),
        .tx_active(tx_active_v[1]), .tx_done(tx_done_v[1])
`ifdef UART_TXQ_OVF_CNT_EN
        , .ovf_cnt(ovfc1)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int inst);
        n_checks++;
        n_err++;
        $display("FAIL %s[%0d] @cyc %0d: timed out", nm, inst, cyc);
    endtask

    // ---------------- behavioural model (queue + launch timestamps) ----------
    logic [7:0] mbuf [2][DEPTH];
    int         mhead[2], msize[2], m_launch_k[2], m_next_ok[2], m_ovfcnt[2];
    bit         m_inflight[2], m_avail[2], m_ovf[2];
    logic [7:0] m_byte[2];

    // logs: launch cycles/bytes, tx_done cycles, overflow pulses seen
    int         l0_cyc[$], l1_cyc[$], d0_cyc[$], d1_cyc[$];
    logic [7:0] l0_byt[$], l1_byt[$];
    int         ovf_seen[2];

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

    task automatic model_step(input int i, input int k);
        bit launch;
        bit full_pre;
        if (rst) begin
            msize[i] = 0; mhead[i] = 0; m_inflight[i] = 0; m_avail[i] = 0;
            m_byte[i] = 8'h00; m_ovf[i] = 0; m_next_ok[i] = 0; m_ovfcnt[i] = 0;
        end else begin
            full_pre = (msize[i] == DEPTH);
            launch   = !m_inflight[i] && (k >= m_next_ok[i]) && (msize[i] > 0) && !tx_active_v[i];
            // a byte is accepted as finished only once the launch cycle is over
            if (m_inflight[i] && k >= m_launch_k[i] + 2 && tx_done_v[i]) begin
                m_inflight[i] = 0;
                m_next_ok[i]  = k + 1 + gap_of(i);
            end
            m_avail[i] = launch;
            if (launch) begin
                m_byte[i]     = mbuf[i][mhead[i]];
                mhead[i]      = (mhead[i] + 1) % DEPTH;
                msize[i]      = msize[i] - 1;
                m_inflight[i] = 1;
                m_launch_k[i] = k;
            end
            m_ovf[i] = wr_en_v[i] && full_pre;
            if (m_ovf[i]) begin
                if (m_ovfcnt[i] < 65535) m_ovfcnt[i] = m_ovfcnt[i] + 1;
            end else if (wr_en_v[i]) begin
                mbuf[i][(mhead[i] + msize[i]) % DEPTH] = wr_data;
                msize[i] = msize[i] + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (tx_done_v[0]) d0_cyc.push_back(cyc);
            if (tx_done_v[1]) d1_cyc.push_back(cyc);
            for (int i = 0; i < 2; i++) model_step(i, cyc);
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare + output logging ----------------------
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (avail_v[0]) begin l0_cyc.push_back(cyc); l0_byt.push_back(byte0); end
                if (avail_v[1]) begin l1_cyc.push_back(cyc); l1_byt.push_back(byte1); end
                for (int i = 0; i < 2; i++) if (ovf_v[i]) ovf_seen[i]++;
                chk("avail", 0, avail_v[0], m_avail[0]);
                chk("byte",  0, byte0,      m_byte[0]);
                chk("count", 0, count0,     msize[0]);
                chk("full",  0, full_v[0],  msize[0] == DEPTH);
                chk("empty", 0, empty_v[0], msize[0] == 0);
                chk("ovf",   0, ovf_v[0],   m_ovf[0]);
                chk("avail", 1, avail_v[1], m_avail[1]);
                chk("byte",  1, byte1,      m_byte[1]);
                chk("count", 1, count1,     msize[1]);
                chk("full",  1, full_v[1],  msize[1] == DEPTH);
                chk("empty", 1, empty_v[1], msize[1] == 0);
                chk("ovf",   1, ovf_v[1],   m_ovf[1]);
`ifdef UART_TXQ_OVF_CNT_EN
                chk("ovf_cnt", 0, ovfc0, m_ovfcnt[0]);
                chk("ovf_cnt", 1, ovfc1, m_ovfcnt[1]);
`endif
            end
        end
    end

    // ---------------- uart_top stand-in: FRAME-cycle frames -------------------
    int bcnt[2];
    initial begin
        r_active_v = 2'b00;
        r_done_v   = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!auto_v[i]) begin
                    r_active_v[i] = 1'b0; r_done_v[i] = 1'b0; bcnt[i] = 0;
                end else begin
                    r_done_v[i] = 1'b0;
                    if (bcnt[i] > 0) begin
                        bcnt[i] = bcnt[i] - 1;
                        if (bcnt[i] == 0) begin
                            r_done_v[i] = 1'b1; r_active_v[i] = 1'b0;
                        end
                    end else if (avail_v[i]) begin
                        r_active_v[i] = 1'b1; bcnt[i] = FRAME;
                    end
                end
            end
        end
    end

    // ---------------- helpers --------------------------------------------------
    function automatic int lc(input int i, input int idx);
        if (i == 0) return (idx < l0_cyc.size()) ? l0_cyc[idx] : -1000;
        return (idx < l1_cyc.size()) ? l1_cyc[idx] : -1000;
    endfunction
    function automatic logic [7:0] lb(input int i, input int idx);
        if (i == 0) return (idx < l0_byt.size()) ? l0_byt[idx] : 8'hxx;
        return (idx < l1_byt.size()) ? l1_byt[idx] : 8'hxx;
    endfunction
    function automatic int dc(input int i, input int idx);
        if (i == 0) return (idx < d0_cyc.size()) ? d0_cyc[idx] : 1000000;
        return (idx < d1_cyc.size()) ? d1_cyc[idx] : 1000000;
    endfunction
    function automatic int nl(input int i);
        return (i == 0) ? l0_cyc.size() : l1_cyc.size();
    endfunction
    function automatic int nd(input int i);
        return (i == 0) ? d0_cyc.size() : d1_cyc.size();
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int i, input logic [7:0] b);
        wr_en_v[i] = 1'b1;
        wr_data    = b;
        @(negedge clk);
        wr_en_v[i] = 1'b0;
    endtask

    task automatic wait_launch(input int i, input int n);
        int t = 0;
        while (nl(i) < n && t < 200) begin tick(); t++; end
        if (nl(i) < n) fail_now("wait_launch", i);
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (!(msize[i] == 0 && !m_inflight[i] && cyc > m_next_ok[i]) && t < 300) begin tick(); t++; end
        if (t >= 300) fail_now("wait_idle", i);
    endtask

    // ---------------- directed stimulus ----------------------------------------
    initial begin
        int a, base, db, nb, ob;
        rst = 1'b1; wr_en_v = 2'b00; wr_data = 8'h00;
        auto_v = 2'b00; man_active_v = 2'b00; man_done_v = 2'b00;
        repeat (3) tick();
        chk("rst_empty", 0, empty_v[0], 1'b1);
        chk("rst_count", 0, count0, 0);
        chk("rst_avail", 0, avail_v[0], 1'b0);
        chk("rst_byte",  0, byte0, 8'h00);
        rst = 1'b0;
        auto_v = 2'b11;
        tick();

        // single byte
        base = nl(0);
        a = cyc;
        wr(0, 8'h54);
        wait_launch(0, base + 1);
        chk("t1_latency", 0, lc(0, base) - a, 2);
        chk("t1_byte",    0, lb(0, base), 8'h54);
        wait_idle(0);
        chk("t1_launches", 0, nl(0) - base, 1);

        // burst of three, held off by tx_active so the queue fills to 3
        base = nl(0); db = nd(0);
        auto_v[0] = 1'b0; man_active_v[0] = 1'b1;
        wr(0, 8'hAA); wr(0, 8'h55); wr(0, 8'h0F);
        chk("t2_count3", 0, count0, 3);
        auto_v[0] = 1'b1;
        wait_launch(0, base + 3);
        wait_idle(0);
        chk("t2_b0", 0, lb(0, base),     8'hAA);
        chk("t2_b1", 0, lb(0, base + 1), 8'h55);
        chk("t2_b2", 0, lb(0, base + 2), 8'h0F);
        chk("t2_gap1", 0, lc(0, base + 1) - dc(0, db),     2);
        chk("t2_gap2", 0, lc(0, base + 2) - dc(0, db + 1), 2);
        chk("t2_count0", 0, count0, 0);

        // overflow: DEPTH+2 writes while uart_top is busy
        base = nl(0); ob = ovf_seen[0];
        auto_v[0] = 1'b0; man_active_v[0] = 1'b1;
        for (int j = 0; j < DEPTH + 2; j++) wr(0, 8'(8'h11 + j));
        tick();
        chk("t3_full", 0, full_v[0], 1'b1);
        chk("t3_ovf_pulses", 0, ovf_seen[0] - ob, 2);
        auto_v[0] = 1'b1;
        wait_launch(0, base + DEPTH);
        wait_idle(0);
        chk("t3_launches", 0, nl(0) - base, DEPTH);
        for (int j = 0; j < DEPTH; j++) chk("t3_byte", 0, lb(0, base + j), 8'(8'h11 + j));
`ifdef UART_TXQ_OVF_CNT_EN
        chk("t3_ovf_cnt", 0, ovfc0, 2);
`endif

        // full queue: write and pop on the same edge
        base = nl(0);
        auto_v[0] = 1'b0; man_active_v[0] = 1'b1;
        for (int j = 0; j < DEPTH; j++) wr(0, 8'(8'h21 + j));
        auto_v[0] = 1'b1;
        wr(0, 8'h99);
        chk("t4_count", 0, count0, DEPTH - 1);
        chk("t4_ovf",   0, ovf_v[0], 1'b1);
        wait_launch(0, base + DEPTH);
        wait_idle(0);
        chk("t4_launches", 0, nl(0) - base, DEPTH);
        for (int j = 0; j < DEPTH; j++) chk("t4_byte", 0, lb(0, base + j), 8'(8'h21 + j));
`ifdef UART_TXQ_OVF_CNT_EN
        chk("t4_ovf_cnt", 0, ovfc0, 3);
`endif

        // reset while a byte is in flight and 4 are queued
        auto_v[0] = 1'b0; man_active_v[0] = 1'b0; man_done_v[0] = 1'b0;
        for (int j = 0; j < 5; j++) wr(0, 8'(8'h31 + j));
        chk("t5_count4", 0, count0, 4);
        rst = 1'b1;
        tick();
        chk("t5_empty", 0, empty_v[0], 1'b1);
        chk("t5_count", 0, count0, 0);
        chk("t5_avail", 0, avail_v[0], 1'b0);
        rst = 1'b0;
        nb = nl(0);
        repeat (10) tick();
        chk("t5_no_launch", 0, nl(0) - nb, 0);
        auto_v[0] = 1'b1;
        wr(0, 8'h3C);
        wait_launch(0, nb + 1);
        chk("t5_new_byte", 0, lb(0, nb), 8'h3C);
        wait_idle(0);

        // IDLE_GAP=5 instance
        base = nl(1); db = nd(1);
        wr(1, 8'h5A); wr(1, 8'hA5);
        wait_launch(1, base + 2);
        chk("t6_gap", 1, lc(1, base + 1) - dc(1, db), 7);
        chk("t6_b1",  1, lb(1, base + 1), 8'hA5);
        wait_idle(1);
        // tx_done while idle must not start a gap
        auto_v[1] = 1'b0; man_done_v[1] = 1'b1;
        tick();
        man_done_v[1] = 1'b0;
        auto_v[1] = 1'b1;
        base = nl(1);
        a = cyc;
        wr(1, 8'h77);
        wait_launch(1, base + 1);
        chk("t6_idle_done", 1, lc(1, base) - a, 2);
        wait_idle(1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog[0] @cyc %0d: simulation did not finish", cyc);
        $fatal(1);
    end

endmodule
